// File: rtl/pdm_pkg.sv
// pdm_pkg
// Shared types and elaboration-time helpers for the PDM microphone capture block.
//   pdm_chan_e : channel tag carried with every amplitude result
//   clk_count  : m_clk half-period in system clock cycles
//   amp_width  : bits needed to hold 0..WINDOW
//   idx_width  : index width for n items, never below 1
package pdm_pkg;

    typedef enum logic {
        PDM_LEFT  = 1'b0,
        PDM_RIGHT = 1'b1
    } pdm_chan_e;

    // Integer-truncated half-period; the 64-bit product avoids overflow for large CLK_FREQ.
    function automatic int unsigned clk_count(input int unsigned clk_freq,
                                              input int unsigned sample_rate);
        logic [63:0] num;
        logic [63:0] den;
        num = 64'(clk_freq) * 64'd1000000;
        den = 64'(sample_rate) << 1;
        return 32'(num / den);
    endfunction

    function automatic int unsigned amp_width(input int unsigned window);
        return $clog2(window + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pdm_capture_if.sv
// pdm_capture_if
// Amplitude result bus from the PDM capture block to its consumer.
//   amplitude       : count of ones in the completed window
//   amplitude_chan  : 0 = left, 1 = right
//   amplitude_phase : integration phase that produced the result
//   amplitude_valid : one-cycle strobe qualifying the fields above
// Modports: master (producer, pdm_capture) and slave (consumer).
interface pdm_capture_if #(
    parameter int unsigned AMP_W   = pdm_pkg::amp_width(128),
    parameter int unsigned PHASE_W = 1
);
    logic [AMP_W-1:0]   amplitude;
    logic               amplitude_chan;
    logic [PHASE_W-1:0] amplitude_phase;
    logic               amplitude_valid;

    modport master (output amplitude, amplitude_chan, amplitude_phase, amplitude_valid);
    modport slave  (input  amplitude, amplitude_chan, amplitude_phase, amplitude_valid);

endinterface

// File: rtl/pdm_clk_gen.sv
// pdm_clk_gen
// Microphone clock generator. Divides clk by 2*CLK_COUNT and flags the cycles on which
// m_clk is about to change, which are the PDM data sampling points.
//   clk, rst   : system clock, synchronous active-high reset
//   enable     : low holds m_clk at 0 and clears the divider
//   m_clk      : microphone clock
//   m_clk_en   : one-cycle pulse in the first cycle m_clk is high
//   rise_tick  : m_clk is low and rises at the next edge (right-channel sample point)
//   fall_tick  : m_clk is high and falls at the next edge (left-channel sample point)
module pdm_clk_gen #(
    parameter int unsigned CLK_COUNT = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic m_clk,
    output logic m_clk_en,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned      CNT_W   = pdm_pkg::idx_width(CLK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_COUNT - 1);

    logic [CNT_W-1:0] clk_counter;
    logic             wrap;

    // Gated by enable so a tick can never fire in the cycle enable drops.
    assign wrap      = enable && (clk_counter == CNT_MAX);
    assign rise_tick = wrap && !m_clk;
    assign fall_tick = wrap && m_clk;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            clk_counter <= '0;
            m_clk       <= 1'b0;
            m_clk_en    <= 1'b0;
        end else begin
            clk_counter <= wrap ? '0 : clk_counter + 1'b1;
            m_clk       <= m_clk ^ wrap;
            m_clk_en    <= rise_tick;
        end
    end

endmodule

// File: rtl/pdm_capture.sv
// pdm_capture
// PDM microphone front end: drives m_clk, samples the shared PDM data line (left on the
// falling half, right on the rising half when STEREO=1) and integrates WINDOW bits per
// result in NUM_PHASES staggered windows per channel.
//   clk, rst  : system clock, synchronous active-high reset
//   enable    : run enable; low stops m_clk and returns all capture state to cold
//   m_clk     : microphone clock
//   m_clk_en  : one-cycle pulse in the first clk cycle m_clk is high
//   m_data    : PDM data from the microphone(s)
//   amp       : result bus (amplitude, amplitude_chan, amplitude_phase, amplitude_valid)
module pdm_capture import pdm_pkg::*; #(
    parameter int unsigned CLK_FREQ    = 100,
    parameter int unsigned SAMPLE_RATE = 2400000,
    parameter int unsigned WINDOW      = 128,
    parameter int unsigned PERIOD      = 200,
    parameter int unsigned NUM_PHASES  = 2,
    parameter int unsigned STEREO      = 0,
    parameter int unsigned DISCARD     = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          m_clk,
    output logic          m_clk_en,
    input  logic          m_data,
    pdm_capture_if.master amp
);

    localparam int unsigned CLK_COUNT = clk_count(CLK_FREQ, SAMPLE_RATE);
    localparam int unsigned AMP_W     = amp_width(WINDOW);
    localparam int unsigned PHASE_W   = idx_width(NUM_PHASES);
    localparam int unsigned TICK_W    = idx_width(PERIOD);
    localparam int unsigned DISC_W    = idx_width(DISCARD + 1);
    localparam int unsigned NUM_CHANS = (STEREO != 0) ? 2 : 1;
    localparam int unsigned NUM_SLOTS = NUM_CHANS * NUM_PHASES;
    localparam int unsigned STRIDE    = PERIOD / NUM_PHASES;

    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(PERIOD - 1);
    localparam logic [AMP_W-1:0]  WIN_LEN  = AMP_W'(WINDOW);
    localparam logic [DISC_W-1:0] DISC_MAX = DISC_W'(DISCARD);

    if (CLK_COUNT < 2) begin : g_bad_clk_count
        $error("pdm_capture: CLK_FREQ/SAMPLE_RATE gives CLK_COUNT below 2");
    end
    if (WINDOW < 1 || WINDOW > PERIOD) begin : g_bad_window
        $error("pdm_capture: WINDOW must be in 1..PERIOD");
    end
    if (NUM_PHASES < 1 || (PERIOD % NUM_PHASES) != 0) begin : g_bad_phases
        $error("pdm_capture: PERIOD must be a multiple of NUM_PHASES");
    end

    logic rise_tick;
    logic fall_tick;

    pdm_clk_gen #(
        .CLK_COUNT (CLK_COUNT)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .m_clk     (m_clk),
        .m_clk_en  (m_clk_en),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Channel 0 (left) ticks at the end of the high half, channel 1 (right) at the end of
    // the low half, so the two channels never tick in the same cycle.
    logic [NUM_CHANS-1:0] chan_tick;

    if (STEREO != 0) begin : g_stereo_ticks
        assign chan_tick = {rise_tick, fall_tick};
    end else begin : g_mono_ticks
        logic unused_rise_tick;
        assign unused_rise_tick = rise_tick;
        assign chan_tick        = fall_tick;
    end

    // Flattened per-slot completion flags and results, slot = chan * NUM_PHASES + phase.
    logic [NUM_SLOTS-1:0] emit;
    logic [AMP_W-1:0]     result [NUM_SLOTS];

    for (genvar c = 0; c < NUM_CHANS; c++) begin : g_chan
        logic [TICK_W-1:0] tick_count;

        always_ff @(posedge clk) begin
            if (rst || !enable) begin
                tick_count <= '0;
            end else if (chan_tick[c]) begin
                tick_count <= (tick_count == TICK_MAX) ? '0 : tick_count + 1'b1;
            end
        end

        for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase
            localparam int unsigned       SLOT  = c * NUM_PHASES + p;
            localparam logic [TICK_W-1:0] START = TICK_W'(p * STRIDE);

            logic              active;
            logic              start;
            logic              step;
            logic              done;
            logic [AMP_W-1:0]  acc;
            logic [AMP_W-1:0]  acc_next;
            logic [AMP_W-1:0]  bits;
            logic [AMP_W-1:0]  bits_next;
            logic [DISC_W-1:0] discarded;

            assign start     = (tick_count == START);
            assign step      = chan_tick[c] && (start || active);
            // The start tick reloads, so the first bit of a window is never added to stale data.
            assign acc_next  = (start ? '0 : acc) + AMP_W'(m_data);
            assign bits_next = (start ? '0 : bits) + 1'b1;
            assign done      = step && (bits_next == WIN_LEN);

            always_ff @(posedge clk) begin
                if (rst || !enable) begin
                    active    <= 1'b0;
                    acc       <= '0;
                    bits      <= '0;
                    discarded <= '0;
                end else if (step) begin
                    acc    <= acc_next;
                    bits   <= bits_next;
                    active <= !done;
                    if (done && (discarded != DISC_MAX)) begin
                        discarded <= discarded + 1'b1;
                    end
                end
            end

            assign emit[SLOT]   = done && (discarded == DISC_MAX);
            assign result[SLOT] = acc_next;
        end
    end

    // Phase starts are distinct and channels tick on different cycles, so at most one slot
    // emits per cycle and a plain scan suffices.
    logic               any_emit;
    logic [AMP_W-1:0]   sel_amp;
    pdm_chan_e          sel_chan;
    logic [PHASE_W-1:0] sel_phase;

    always_comb begin
        any_emit  = 1'b0;
        sel_amp   = '0;
        sel_chan  = PDM_LEFT;
        sel_phase = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (emit[i]) begin
                any_emit  = 1'b1;
                sel_amp   = result[i];
                sel_chan  = (i >= NUM_PHASES) ? PDM_RIGHT : PDM_LEFT;
                sel_phase = PHASE_W'(i % NUM_PHASES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            amp.amplitude_valid <= 1'b0;
            amp.amplitude       <= '0;
            amp.amplitude_chan  <= PDM_LEFT;
            amp.amplitude_phase <= '0;
        end else begin
            amp.amplitude_valid <= any_emit;
            if (any_emit) begin
                amp.amplitude       <= sel_amp;
                amp.amplitude_chan  <= sel_chan;
                amp.amplitude_phase <= sel_phase;
            end
        end
    end

endmodule
